// File: rtl/cipher_session_arbiter.sv
// Shares one stream_cipher between two requesters: round-robin grant per message,
// cipher counter reload via a one-cycle reset pulse, and per-requester ciphertext routing.
module cipher_session_arbiter #(
   parameter int unsigned MAX_LEN = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_0,
   input  logic       req_1,
   input  logic [7:0] key_0,
   input  logic [7:0] key_1,
   input  logic       in_valid_0,
   input  logic       in_valid_1,
   input  logic [7:0] in_char_0,
   input  logic [7:0] in_char_1,
   input  logic       in_last_0,
   input  logic       in_last_1,
   output logic       in_ready_0,
   output logic       in_ready_1,
   output logic       out_valid_0,
   output logic       out_valid_1,
   output logic [7:0] out_char_0,
   output logic [7:0] out_char_1,
   output logic       done_0,
   output logic       done_1,
   output logic       cph_rst_n,
   output logic [7:0] cph_key,
   output logic [7:0] cph_ptxt,
   output logic       cph_din_valid,
   input  logic [7:0] cph_ctxt,
   input  logic       cph_dout_valid
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN
   } state_t;

   localparam logic [8:0] LP_MAX_LEN = 9'(MAX_LEN);

   state_t     r_state;
   logic       r_grant;
   logic       r_prio;
   logic [7:0] r_cph_key;
   logic       r_cph_rst_n;
   logic [8:0] r_cnt;

   state_t     w_state_nxt;
   logic       w_grant_nxt;
   logic       w_prio_nxt;
   logic [7:0] w_key_nxt;
   logic       w_rst_n_nxt;
   logic [8:0] w_cnt_nxt;
   logic       w_winner;
   logic       w_in_ready;
   logic       w_done;
   logic       w_sel_valid;
   logic       w_sel_last;
   logic       w_accept;
   logic [8:0] w_cnt_inc;

   assign w_in_ready  = (r_state == ST_STREAM);
   assign w_done      = (r_state == ST_DRAIN);
   assign w_sel_valid = r_grant ? in_valid_1 : in_valid_0;
   assign w_sel_last  = r_grant ? in_last_1 : in_last_0;
   assign w_accept    = w_in_ready & w_sel_valid;
   assign w_cnt_inc   = r_cnt + 9'd1;
   // Contended requests go to the preferred requester; a lone request wins outright.
   assign w_winner    = (req_0 & req_1) ? r_prio : req_1;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_prio_nxt  = r_prio;
      w_key_nxt   = r_cph_key;
      w_rst_n_nxt = 1'b1;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (req_0 | req_1) begin
               w_grant_nxt = w_winner;
               w_key_nxt   = w_winner ? key_1 : key_0;
               w_cnt_nxt   = '0;
               w_rst_n_nxt = 1'b0;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            if (w_accept) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_sel_last || (w_cnt_inc == LP_MAX_LEN)) begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            w_prio_nxt  = ~r_grant;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_grant     <= 1'b0;
         r_prio      <= 1'b0;
         r_cph_key   <= '0;
         r_cph_rst_n <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_prio      <= w_prio_nxt;
         r_cph_key   <= w_key_nxt;
         r_cph_rst_n <= w_rst_n_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   // grant is held through DRAIN so the final ciphertext still routes to its owner.
   assign in_ready_0    = w_in_ready & ~r_grant;
   assign in_ready_1    = w_in_ready & r_grant;
   assign done_0        = w_done & ~r_grant;
   assign done_1        = w_done & r_grant;
   assign out_valid_0   = cph_dout_valid & ~r_grant;
   assign out_valid_1   = cph_dout_valid & r_grant;
   assign out_char_0    = cph_ctxt;
   assign out_char_1    = cph_ctxt;
   assign cph_rst_n     = r_cph_rst_n;
   assign cph_key       = r_cph_key;
   assign cph_ptxt      = r_grant ? in_char_1 : in_char_0;
   assign cph_din_valid = w_accept;

endmodule

// File: doc/cipher_session_arbiter.md
# cipher_session_arbiter

Session controller that shares one `stream_cipher` instance between two requesters. For each message it grants one requester and reloads the cipher's counter block with that requester's key by pulsing the cipher's reset. It then streams the requester's characters through the cipher and routes the ciphertext back to the same requester. Grants alternate round-robin at message granularity. It sits directly in front of the cipher.

## Interface
- MAX_LEN, 256: maximum characters per session. Legal range 1..256, because the keystream repeats after 256 characters. The session is force-terminated at this count.
- clk  in  1  clock; everything below is synchronous to its rising edge
- rst  in  1  synchronous, active-high reset
- req_0 / req_1  in  1  level session request; sampled only in IDLE
- key_0 / key_1  in  8  session key; captured at grant
- in_valid_0 / in_valid_1  in  1  plaintext character valid
- in_char_0 / in_char_1  in  8  plaintext character
- in_last_0 / in_last_1  in  1  marks the final character of the message; qualified by in_valid & in_ready
- in_ready_0 / in_ready_1  out  1  controller accepts a character this cycle
- out_valid_0 / out_valid_1  out  1  ciphertext valid
- out_char_0 / out_char_1  out  8  ciphertext character (shared cipher output, qualified per port)
- done_0 / done_1  out  1  one-cycle end-of-session pulse
- cph_rst_n  out  1  drives cipher rst_n; registered output, glitch-free
- cph_key  out  8  drives cipher key; registered
- cph_ptxt  out  8  drives cipher ptxt_char
- cph_din_valid  out  1  drives cipher din_valid
- cph_ctxt  in  8  from cipher ctxt_char
- cph_dout_valid  in  1  from cipher dout_valid

## Operation
- States: IDLE, LOAD, STREAM, DRAIN. Registers: state, grant (1 bit), prio (1 bit, the next preferred requester), cph_key, cph_rst_n, cnt (9 bits).
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant prio.
  - On grant: grant<=winner, cph_key<=key_winner, cnt<=0, cph_rst_n<=0, go to LOAD.
- **LOAD** (exactly 1 cycle)
  - cph_rst_n is low for this whole cycle; the cipher loads cb<=cph_key.
  - Exit: cph_rst_n<=1, go to STREAM.
- **STREAM**
  - in_ready_grant=1; in_ready of the other requester is 0.
  - cph_din_valid = in_valid_grant & in_ready_grant; cph_ptxt = in_char_grant (combinational mux).
  - On each accepted character: cnt<=cnt+1.
  - Exit when an accepted character has in_last=1, or cnt+1==MAX_LEN: go to DRAIN, and in_ready drops the next cycle.
  - Gaps (in_valid=0) are allowed and hold the state.
  - Deasserting req mid-session is ignored.
- **DRAIN** (exactly 1 cycle)
  - done_grant=1.
  - prio<=~grant.
  - Go to IDLE.
- **Output routing** (valid in any state):
  - out_valid_i = cph_dout_valid & (grant==i).
  - out_char_i = cph_ctxt.
  - grant holds from the grant cycle through DRAIN, so the final ciphertext is routed correctly.
- **Cipher contract**
  - The k-th accepted character of a session (k from 0) is encrypted as ptxt ^ S((key+k) mod 256).
  - Every session restarts the counter at its key.
- **Reset**, synchronous, overriding any state, mid-session included:
  - state=IDLE, grant=0, prio=0, cph_key=0, cnt=0, cph_rst_n=0 (cipher held in reset while rst=1).
  - cph_rst_n=1 from the first cycle after rst deasserts.
  - All in_ready, done and cph_din_valid outputs are 0.
  - out_valid_i is 0, because the cipher's dout_valid is cleared by cph_rst_n.
  - Any in-flight session is abandoned with no done pulse.

## Timing
- Grant sampled at edge t (IDLE) → LOAD cycle t+1 → in_ready high from t+2.
- Character accepted in cycle s → out_valid_i in cycle s+1 (cipher latency 1). Throughput is 1 char/cycle.
- Last character accepted in cycle s → DRAIN at s+1, with done and the final out_valid in the same cycle → IDLE at s+2.
- Earliest next LOAD is s+3. Per-session overhead is 3 cycles (IDLE, LOAD, DRAIN).
- cph_key is stable from the LOAD cycle to the next grant.
- cph_din_valid is never asserted in IDLE, LOAD or DRAIN.
- A single-character session (last on the first character) is legal: LOAD, STREAM (1 cycle), DRAIN.
- MAX_LEN force-end: the MAX_LEN-th accepted character terminates the session whether or not in_last is set.

## Test plan
- **Single session:** req_0=1, key_0=0x10, send 3 chars 0x41,0x42,0x43 with last on the third → in_ready_0 two cycles after grant; cph_rst_n low exactly 1 cycle; outputs 0x41^S(0x10), 0x42^S(0x11), 0x43^S(0x12), each 1 cycle after acceptance; done_0 with the third output; req_1 port stays silent.
- **Simultaneous requests:** req_0=req_1=1 from reset → requester 0 served first, then requester 1 (key reloaded, first output uses S(key_1)); repeated double requests alternate 0,1,0,1.
- **Counter wrap:** key=0xFE, 4 chars → keystream uses S(0xFE), S(0xFF), S(0x00), S(0x01).
- **Force-end:** MAX_LEN=4, 6 valid chars with no last → exactly 4 accepted, done after the 4th output, in_ready low thereafter.
- **Gaps:** in_valid toggling 1,0,0,1 in STREAM → 2 chars encrypted with consecutive keystream bytes and no extra cph_din_valid.
- **Reset mid-session:** rst asserted after the 2nd char → next cycle IDLE, cph_rst_n=0, in_ready=0, no done; a fresh session after release starts at S(key).
